// File: rtl/cache_dm_wb_param_if.sv
// CPU-side and memory-side bus bundle for the direct-mapped write-back cache.
// Defining CACHE_STATS_EN adds the hit/miss/write-back counter outputs.
interface cache_dm_wb_param_if #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hit;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ack;

`ifdef CACHE_STATS_EN
  logic [31:0]       stat_hits;
  logic [31:0]       stat_misses;
  logic [31:0]       stat_wbacks;
`endif

  // The cache itself is the slave; the CPU/memory environment is the master.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_ready, cpu_valid, cpu_rdata, cpu_hit,
           mem_req, mem_we, mem_addr, mem_wdata
`ifdef CACHE_STATS_EN
    , output stat_hits, stat_misses, stat_wbacks
`endif
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_ready, cpu_valid, cpu_rdata, cpu_hit,
           mem_req, mem_we, mem_addr, mem_wdata
`ifdef CACHE_STATS_EN
    , input stat_hits, stat_misses, stat_wbacks
`endif
  );
endinterface

// File: rtl/cache_dm_wb_param.sv
// Clocked direct-mapped, write-back, write-allocate data cache with req/ready/valid handshakes.
// Optional saturating statistics counters are enabled by defining CACHE_STATS_EN.
module cache_dm_wb_param #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int NUM_LINES      = 4
) (
  input logic                clk,
  input logic                rst,
  cache_dm_wb_param_if.slave bus
);
  localparam int LINE_W = DATA_W * WORDS_PER_LINE;
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int WOFF_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W  = BYTE_W + WOFF_W;
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, REFILL} state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                missFlag_q, missFlag_d;
  logic                reqWe_q;
  logic [ADDR_W-1:0]   reqAddr_q;
  logic [DATA_W-1:0]   reqWdata_q;
  logic                accept;

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q [NUM_LINES];
  logic [TAG_W-1:0]     tag_d [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic                 lineWe;
  logic [LINE_W-1:0]    lineWdata;

  logic                cpuValid_q, cpuValid_d;
  logic                cpuHit_q, cpuHit_d;
  logic [DATA_W-1:0]   cpuRdata_q, cpuRdata_d;
  logic                memReq_q, memReq_d;
  logic                memWe_q, memWe_d;
  logic [ADDR_W-1:0]   memAddr_q, memAddr_d;
  logic [LINE_W-1:0]   memWdata_q, memWdata_d;
  logic                wbDone;

  logic [TAG_W-1:0]    reqTag;
  logic [IDX_W-1:0]    reqIdx;
  logic [WOFF_W-1:0]   reqWord;
  logic [TAG_W-1:0]    curTag;
  logic [LINE_W-1:0]   curLine;
  logic                hit;
  logic                memAck;
  logic                unusedAddr;

  assign reqTag     = reqAddr_q[ADDR_W-1 -: TAG_W];
  assign reqIdx     = reqAddr_q[OFF_W +: IDX_W];
  assign reqWord    = reqAddr_q[BYTE_W +: WOFF_W];
  assign curTag     = tag_q[reqIdx];
  assign curLine    = data_q[reqIdx];
  assign hit        = valid_q[reqIdx] && (curTag == reqTag);
  // An acknowledge is only meaningful while a memory request is outstanding.
  assign memAck     = bus.mem_ack && memReq_q;
  assign unusedAddr = ^reqAddr_q;

  always_comb begin
    state_d    = state_q;
    missFlag_d = missFlag_q;
    accept     = 1'b0;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    tag_d      = tag_q;
    lineWe     = 1'b0;
    lineWdata  = curLine;
    cpuValid_d = 1'b0;
    cpuHit_d   = 1'b0;
    cpuRdata_d = cpuRdata_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    wbDone     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ready_q && bus.cpu_req) begin
          accept     = 1'b1;
          missFlag_d = 1'b0;
          state_d    = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          cpuValid_d = 1'b1;
          cpuHit_d   = !missFlag_q;
          state_d    = IDLE;
          if (reqWe_q) begin
            lineWdata[reqWord*DATA_W +: DATA_W] = reqWdata_q;
            lineWe           = 1'b1;
            dirty_d[reqIdx]  = 1'b1;
          end else begin
            cpuRdata_d = curLine[reqWord*DATA_W +: DATA_W];
          end
        end else begin
          missFlag_d = 1'b1;
          memReq_d   = 1'b1;
          if (valid_q[reqIdx] && dirty_q[reqIdx]) begin
            state_d    = WRITEBACK;
            memWe_d    = 1'b1;
            memAddr_d  = {curTag, reqIdx, {OFF_W{1'b0}}};
            memWdata_d = curLine;
          end else begin
            state_d   = REFILL;
            memWe_d   = 1'b0;
            memAddr_d = {reqTag, reqIdx, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        // The refill request follows straight on; mem_req stays high across the switch.
        if (memAck) begin
          dirty_d[reqIdx] = 1'b0;
          wbDone          = 1'b1;
          state_d         = REFILL;
          memWe_d         = 1'b0;
          memAddr_d       = {reqTag, reqIdx, {OFF_W{1'b0}}};
        end
      end
      REFILL: begin
        if (memAck) begin
          memReq_d        = 1'b0;
          lineWe          = 1'b1;
          lineWdata       = bus.mem_rdata;
          valid_d[reqIdx] = 1'b1;
          dirty_d[reqIdx] = 1'b0;
          tag_d[reqIdx]   = reqTag;
          state_d         = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      missFlag_q <= 1'b0;
      reqWe_q    <= 1'b0;
      reqAddr_q  <= '0;
      reqWdata_q <= '0;
      valid_q    <= '0;
      dirty_q    <= '0;
      tag_q      <= '{default: '0};
      cpuValid_q <= 1'b0;
      cpuHit_q   <= 1'b0;
      cpuRdata_q <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      missFlag_q <= missFlag_d;
      if (accept) begin
        reqWe_q    <= bus.cpu_we;
        reqAddr_q  <= bus.cpu_addr;
        reqWdata_q <= bus.cpu_wdata;
      end
      valid_q    <= valid_d;
      dirty_q    <= dirty_d;
      tag_q      <= tag_d;
      cpuValid_q <= cpuValid_d;
      cpuHit_q   <= cpuHit_d;
      cpuRdata_q <= cpuRdata_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  // Line storage carries no reset; the valid bits guard its contents.
  always_ff @(posedge clk) begin
    if (lineWe) begin
      data_q[reqIdx] <= lineWdata;
    end
  end

  assign bus.cpu_ready = ready_q;
  assign bus.cpu_valid = cpuValid_q;
  assign bus.cpu_hit   = cpuHit_q;
  assign bus.cpu_rdata = cpuRdata_q;
  assign bus.mem_req   = memReq_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] statHits_q, statMisses_q, statWbacks_q;

  // Counters saturate at all-ones and count in step with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      statHits_q   <= '0;
      statMisses_q <= '0;
      statWbacks_q <= '0;
    end else begin
      if (cpuValid_d && cpuHit_d && !(&statHits_q)) begin
        statHits_q <= statHits_q + 32'd1;
      end
      if (cpuValid_d && !cpuHit_d && !(&statMisses_q)) begin
        statMisses_q <= statMisses_q + 32'd1;
      end
      if (wbDone && !(&statWbacks_q)) begin
        statWbacks_q <= statWbacks_q + 32'd1;
      end
    end
  end

  assign bus.stat_hits   = statHits_q;
  assign bus.stat_misses = statMisses_q;
  assign bus.stat_wbacks = statWbacks_q;
`endif
endmodule

// File: tb/tb_cache_dm_wb_param.sv
// Scoreboard bench for cache_dm_wb_param: expected CPU responses and memory transactions are
// queued per scenario and compared with what the cache produces. Define CACHE_STATS_EN to check counters.
module tb_cache_dm_wb_param;
  typedef struct packed {
    logic         we;
    logic [9:0]   addr;
    logic [127:0] wdata;
  } memTxn_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        hit;
    logic [31:0] latency;
  } cpuRsp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   stableErrs;
  int   readyErrs;
  int   postErrs;

  logic [127:0] memLines [64];
  memTxn_t      expMemQ[$];
  memTxn_t      obsMemQ[$];
  cpuRsp_t      expRspQ[$];
  cpuRsp_t      obsRspQ[$];

  cache_dm_wb_param_if #(.ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4)) bus ();

  cache_dm_wb_param #(
    .ADDR_W(10), .DATA_W(32), .WORDS_PER_LINE(4), .NUM_LINES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] linePattern(input int i);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) begin
      l[w*32 +: 32] = 32'hA500_0000 | (32'(i) << 8) | 32'(w);
    end
    return l;
  endfunction

  // Drives one CPU access and plays memory, recording responses and transactions.
  task automatic doAccess(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                          input int ackDelay, input bit poke);
    int      k;
    int      spin;
    int      countdown;
    bit      inTxn;
    bit      done;
    memTxn_t snap;
    cpuRsp_t rsp;
    stableErrs = 0;
    readyErrs  = 0;
    postErrs   = 0;
    spin       = 0;
    while (bus.cpu_ready !== 1'b1 && spin < 50) begin
      @(negedge clk);
      spin++;
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    k         = 0;
    inTxn     = 1'b0;
    done      = 1'b0;
    countdown = 0;
    while (!done && k < 200) begin
      if (bus.cpu_valid === 1'b1) begin
        rsp.rdata   = bus.cpu_rdata;
        rsp.hit     = bus.cpu_hit;
        rsp.latency = 32'(k);
        obsRspQ.push_back(rsp);
        done = 1'b1;
      end else if (bus.mem_req === 1'b1) begin
        if (!inTxn) begin
          snap = '{we: bus.mem_we, addr: bus.mem_addr, wdata: bus.mem_wdata};
          obsMemQ.push_back(snap);
          inTxn     = 1'b1;
          countdown = ackDelay;
        end else begin
          if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== snap) stableErrs++;
          if (bus.cpu_ready !== 1'b0) readyErrs++;
        end
        if (countdown == 0) begin
          bus.cpu_req   = 1'b0;
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = memLines[bus.mem_addr[9:4]];
          if (bus.mem_we === 1'b1) memLines[bus.mem_addr[9:4]] = bus.mem_wdata;
          inTxn = 1'b0;
        end else begin
          countdown--;
          if (poke) begin
            bus.cpu_req  = ~bus.cpu_req;
            bus.cpu_we   = 1'b0;
            bus.cpu_addr = 10'h3F0;
          end
        end
      end
      if (!done) begin
        @(negedge clk);
        bus.mem_ack = 1'b0;
        k++;
      end
    end
    bus.cpu_req = 1'b0;
    if (done) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (bus.cpu_valid !== 1'b0 || bus.mem_req !== 1'b0) postErrs++;
        if (bus.cpu_ready !== 1'b1) readyErrs++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.cpu_ready, bus.cpu_valid, bus.cpu_hit, bus.mem_req, bus.mem_we} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got rdy/vld/hit/req/we=%b, expected 00000",
               {bus.cpu_ready, bus.cpu_valid, bus.cpu_hit, bus.mem_req, bus.mem_we});
    end
    checks++;
    if (bus.mem_addr !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_mem_addr: got %h, expected 000", bus.mem_addr);
    end
    checks++;
    if (bus.cpu_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h, expected 00000000", bus.cpu_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.cpu_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b, expected 1", bus.cpu_ready);
    end
  endtask

  task automatic test_refill_read();
    cpuRsp_t e, o;
    memTxn_t em, om;
    expRspQ.push_back('{rdata: 32'h11111111, hit: 1'b0, latency: 32'd3});
    expMemQ.push_back('{we: 1'b0, addr: 10'h040, wdata: '0});
    doAccess(1'b0, 10'h044, 32'h0, 0, 1'b0);
    checks++;
    if (obsRspQ.size() != expRspQ.size() || obsMemQ.size() != expMemQ.size()) begin
      errors++;
      $display("[TB] FAIL refill_read counts: got rsp=%0d mem=%0d, expected rsp=%0d mem=%0d",
               obsRspQ.size(), obsMemQ.size(), expRspQ.size(), expMemQ.size());
    end
    while (expRspQ.size() > 0 && obsRspQ.size() > 0) begin
      e = expRspQ.pop_front();
      o = obsRspQ.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL refill_read rsp: got rdata=%h hit=%b lat=%0d, expected rdata=%h hit=%b lat=%0d",
                 o.rdata, o.hit, o.latency, e.rdata, e.hit, e.latency);
      end
    end
    while (expMemQ.size() > 0 && obsMemQ.size() > 0) begin
      em = expMemQ.pop_front();
      om = obsMemQ.pop_front();
      checks++;
      if (om.we !== em.we || om.addr !== em.addr) begin
        errors++;
        $display("[TB] FAIL refill_read mem: got we=%b addr=%h, expected we=%b addr=%h",
                 om.we, om.addr, em.we, em.addr);
      end
    end
    checks++;
    if (postErrs != 0) begin
      errors++;
      $display("[TB] FAIL refill_read pulse: got %0d extra valid/req samples, expected 0", postErrs);
    end
    expRspQ.delete(); obsRspQ.delete(); expMemQ.delete(); obsMemQ.delete();
  endtask

  task automatic test_write_hit();
    cpuRsp_t e, o;
    expRspQ.push_back('{rdata: 32'h11111111, hit: 1'b1, latency: 32'd1});
    expRspQ.push_back('{rdata: 32'hDEADBEEF, hit: 1'b1, latency: 32'd1});
    doAccess(1'b1, 10'h048, 32'hDEADBEEF, 0, 1'b0);
    doAccess(1'b0, 10'h048, 32'h0, 0, 1'b0);
    checks++;
    if (obsRspQ.size() != 2 || obsMemQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL write_hit counts: got rsp=%0d mem=%0d, expected rsp=2 mem=0",
               obsRspQ.size(), obsMemQ.size());
    end
    while (expRspQ.size() > 0 && obsRspQ.size() > 0) begin
      e = expRspQ.pop_front();
      o = obsRspQ.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL write_hit rsp: got rdata=%h hit=%b lat=%0d, expected rdata=%h hit=%b lat=%0d",
                 o.rdata, o.hit, o.latency, e.rdata, e.hit, e.latency);
      end
    end
    expRspQ.delete(); obsRspQ.delete(); expMemQ.delete(); obsMemQ.delete();
  endtask

  task automatic test_dirty_evict();
    cpuRsp_t e, o;
    memTxn_t em, om;
    logic [127:0] p;
    p = linePattern(8);
    expMemQ.push_back('{we: 1'b1, addr: 10'h040,
                        wdata: {32'h33333333, 32'hDEADBEEF, 32'h11111111, 32'h00000000}});
    expMemQ.push_back('{we: 1'b0, addr: 10'h080, wdata: '0});
    expRspQ.push_back('{rdata: p[31:0], hit: 1'b0, latency: 32'd4});
    doAccess(1'b0, 10'h080, 32'h0, 0, 1'b0);
    checks++;
    if (obsRspQ.size() != 1 || obsMemQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL dirty_evict counts: got rsp=%0d mem=%0d, expected rsp=1 mem=2",
               obsRspQ.size(), obsMemQ.size());
    end
    while (expMemQ.size() > 0 && obsMemQ.size() > 0) begin
      em = expMemQ.pop_front();
      om = obsMemQ.pop_front();
      checks++;
      if (om.we !== em.we || om.addr !== em.addr || (em.we && om.wdata !== em.wdata)) begin
        errors++;
        $display("[TB] FAIL dirty_evict mem: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                 om.we, om.addr, om.wdata, em.we, em.addr, em.wdata);
      end
    end
    while (expRspQ.size() > 0 && obsRspQ.size() > 0) begin
      e = expRspQ.pop_front();
      o = obsRspQ.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL dirty_evict rsp: got rdata=%h hit=%b lat=%0d, expected rdata=%h hit=%b lat=%0d",
                 o.rdata, o.hit, o.latency, e.rdata, e.hit, e.latency);
      end
    end
    expRspQ.delete(); obsRspQ.delete(); expMemQ.delete(); obsMemQ.delete();
  endtask

  task automatic test_clean_miss_stall();
    cpuRsp_t e, o;
    memTxn_t em, om;
    logic [127:0] p;
    p = linePattern(12);
    expMemQ.push_back('{we: 1'b0, addr: 10'h0C0, wdata: '0});
    expRspQ.push_back('{rdata: p[31:0], hit: 1'b0, latency: 32'd8});
    doAccess(1'b0, 10'h0C0, 32'h0, 5, 1'b1);
    checks++;
    if (obsRspQ.size() != 1 || obsMemQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL clean_miss counts: got rsp=%0d mem=%0d, expected rsp=1 mem=1",
               obsRspQ.size(), obsMemQ.size());
    end
    while (expMemQ.size() > 0 && obsMemQ.size() > 0) begin
      em = expMemQ.pop_front();
      om = obsMemQ.pop_front();
      checks++;
      if (om.we !== em.we || om.addr !== em.addr) begin
        errors++;
        $display("[TB] FAIL clean_miss mem: got we=%b addr=%h, expected we=%b addr=%h",
                 om.we, om.addr, em.we, em.addr);
      end
    end
    while (expRspQ.size() > 0 && obsRspQ.size() > 0) begin
      e = expRspQ.pop_front();
      o = obsRspQ.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL clean_miss rsp: got rdata=%h hit=%b lat=%0d, expected rdata=%h hit=%b lat=%0d",
                 o.rdata, o.hit, o.latency, e.rdata, e.hit, e.latency);
      end
    end
    checks++;
    if (stableErrs != 0) begin
      errors++;
      $display("[TB] FAIL clean_miss stable: got %0d changed samples, expected 0", stableErrs);
    end
    checks++;
    if (readyErrs != 0 || postErrs != 0) begin
      errors++;
      $display("[TB] FAIL clean_miss ignore_req: got ready_errs=%0d post_errs=%0d, expected 0 and 0",
               readyErrs, postErrs);
    end
    expRspQ.delete(); obsRspQ.delete(); expMemQ.delete(); obsMemQ.delete();
  endtask

`ifdef CACHE_STATS_EN
  task automatic test_stats();
    checks++;
    if ({bus.stat_hits, bus.stat_misses, bus.stat_wbacks} !== {32'd2, 32'd3, 32'd1}) begin
      errors++;
      $display("[TB] FAIL stats: got hits=%0d misses=%0d wbacks=%0d, expected 2 3 1",
               bus.stat_hits, bus.stat_misses, bus.stat_wbacks);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int spin;
    int validSeen;
    cpuRsp_t e, o;
    memTxn_t om;
    logic [127:0] p;
    spin = 0;
    while (bus.cpu_ready !== 1'b1 && spin < 50) begin
      @(negedge clk);
      spin++;
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 10'h004;
    @(posedge clk);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    spin = 0;
    while (bus.mem_req !== 1'b1 && spin < 20) begin
      @(negedge clk);
      spin++;
    end
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 10'h000) begin
      errors++;
      $display("[TB] FAIL reset_mid refill: got req=%b we=%b addr=%h, expected 1 0 000",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid drop: got mem_req=%b ready=%b, expected 0 0",
               bus.mem_req, bus.cpu_ready);
    end
    validSeen = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.cpu_valid !== 1'b0) validSeen++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_valid !== 1'b0 || bus.mem_req !== 1'b0) validSeen++;
    end
    checks++;
    if (validSeen != 0) begin
      errors++;
      $display("[TB] FAIL reset_mid quiet: got %0d valid/req samples, expected 0", validSeen);
    end
    p = linePattern(12);
    expRspQ.push_back('{rdata: p[31:0], hit: 1'b0, latency: 32'd3});
    doAccess(1'b0, 10'h0C0, 32'h0, 0, 1'b0);
    checks++;
    if (obsMemQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL reset_mid mem_count: got %0d, expected 1", obsMemQ.size());
    end
    while (obsMemQ.size() > 0) begin
      om = obsMemQ.pop_front();
      checks++;
      if (om.we !== 1'b0 || om.addr !== 10'h0C0) begin
        errors++;
        $display("[TB] FAIL reset_mid mem: got we=%b addr=%h, expected we=0 addr=0c0", om.we, om.addr);
      end
    end
    checks++;
    if (obsRspQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL reset_mid rsp_count: got %0d, expected 1", obsRspQ.size());
    end
    while (expRspQ.size() > 0 && obsRspQ.size() > 0) begin
      e = expRspQ.pop_front();
      o = obsRspQ.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid rsp: got rdata=%h hit=%b lat=%0d, expected rdata=%h hit=%b lat=%0d",
                 o.rdata, o.hit, o.latency, e.rdata, e.hit, e.latency);
      end
    end
    expRspQ.delete(); obsRspQ.delete(); expMemQ.delete(); obsMemQ.delete();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    for (int i = 0; i < 64; i++) memLines[i] = linePattern(i);
    memLines[4] = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    $display("[TB] starting cache_dm_wb_param bench");
    test_reset();
    test_refill_read();
    test_write_hit();
    test_dirty_evict();
    test_clean_miss_stall();
`ifdef CACHE_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
